mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 11 +
 rtl/mem_arbiter_if.sv | 52 +++++
 rtl/mem_arbiter.sv | 116 +++++++++++
 tb/tb_mem_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory arbiter.
// Holds the arbiter FSM state encoding.
package rv32i_types;

  typedef enum logic [1:0] {
    IDLE,
    SERVE_A,
    SERVE_B
  } mem_arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and physical-memory signal bundle for mem_arbiter.
// slave = arbiter view, master = requester/memory view.
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32
);

  logic                  read_a;
  logic [ADDR_WIDTH-1:0] address_a;
  logic                  resp_a;
  logic [31:0]           rdata_a;

  logic                  read_b;
  logic                  write;
  logic [ADDR_WIDTH-1:0] address_b;
  logic [31:0]           wdata;
  logic [3:0]            wmask;
  logic                  resp_b;
  logic [31:0]           rdata_b;

  logic                  pmem_read;
  logic                  pmem_write;
  logic [ADDR_WIDTH-1:0] pmem_address;
  logic [31:0]           pmem_wdata;
  logic [3:0]            pmem_wmask;
  logic                  pmem_resp;
  logic [31:0]           pmem_rdata;

  modport slave (
    input  read_a, address_a,
    input  read_b, write, address_b,
    input  wdata, wmask,
    input  pmem_resp, pmem_rdata,
    output resp_a, rdata_a,
    output resp_b, rdata_b,
    output pmem_read, pmem_write,
    output pmem_address,
    output pmem_wdata, pmem_wmask
  );

  modport master (
    output read_a, address_a,
    output read_b, write, address_b,
    output wdata, wmask,
    output pmem_resp, pmem_rdata,
    input  resp_a, rdata_a,
    input  resp_b, rdata_b,
    input  pmem_read, pmem_write,
    input  pmem_address,
    input  pmem_wdata, pmem_wmask
  );

endinterface

// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) arbiter onto one physical memory port.
// MEM_ARB_DPRIO_EN: data side wins ties; otherwise ties alternate.
module mem_arbiter
  import rv32i_types::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input logic         clk,
  input logic         rst,
  mem_arbiter_if.slave bus
);

  mem_arb_state_t state;
  mem_arb_state_t next;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [3:0]            wmask_q;
  logic                  wr_q;

  logic pend_a;
  logic pend_b;
  logic grant_a;
  logic grant_b;
  logic busy;

  assign pend_a = bus.read_a;
  assign pend_b = bus.read_b | bus.write;

`ifndef MEM_ARB_DPRIO_EN
  // Set when A won the most recent tie.
  logic last_a;
`endif

  always_comb begin
    next    = state;
    grant_a = 1'b0;
    grant_b = 1'b0;
    unique case (state)
      IDLE: begin
        if (pend_a && pend_b) begin
`ifdef MEM_ARB_DPRIO_EN
          grant_b = 1'b1;
`else
          grant_a = !last_a;
          grant_b = last_a;
`endif
        end else begin
          grant_a = pend_a;
          grant_b = pend_b;
        end
        if (grant_a)
          next = SERVE_A;
        else if (grant_b)
          next = SERVE_B;
      end
      SERVE_A, SERVE_B: begin
        if (bus.pmem_resp)
          next = IDLE;
      end
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      wr_q    <= 1'b0;
    end else begin
      state <= next;
      if (grant_a) begin
        addr_q  <= bus.address_a;
        wdata_q <= '0;
        wmask_q <= '0;
        wr_q    <= 1'b0;
      end else if (grant_b) begin
        addr_q  <= bus.address_b;
        wdata_q <= bus.wdata;
        wmask_q <= bus.wmask;
        wr_q    <= bus.write;
      end
    end
  end

`ifndef MEM_ARB_DPRIO_EN
  always_ff @(posedge clk) begin
    if (rst)
      last_a <= 1'b0;
    else if (state == IDLE && pend_a && pend_b)
      last_a <= grant_a;
  end
`endif

  // Gated by rst so a pending reset silences the bus at once.
  assign busy = (state != IDLE) && !rst;

  assign bus.pmem_read    = busy && !wr_q;
  assign bus.pmem_write   = busy && wr_q;
  assign bus.pmem_address = addr_q;
  assign bus.pmem_wdata   = wdata_q;
  assign bus.pmem_wmask   = wmask_q;

  assign bus.resp_a = busy && (state == SERVE_A)
                      && bus.pmem_resp;
  assign bus.resp_b = busy && (state == SERVE_B)
                      && bus.pmem_resp;

  assign bus.rdata_a = bus.resp_a
                       ? bus.pmem_rdata : 32'h0;
  assign bus.rdata_b = (bus.resp_b && !wr_q)
                       ? bus.pmem_rdata : 32'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized self-checking bench for mem_arbiter.
// Reference model tracks grant order and expected bus values.
module tb_mem_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  bit   model_last_a;

  mem_arbiter_if #(.ADDR_WIDTH(32)) bus ();

  mem_arbiter #(.ADDR_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.read_a     = 1'b0;
    bus.address_a  = '0;
    bus.read_b     = 1'b0;
    bus.write      = 1'b0;
    bus.address_b  = '0;
    bus.wdata      = '0;
    bus.wmask      = '0;
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = '0;
  endtask

  // Serve one transaction the model says is next.
  task automatic do_txn(
    input bit          side_b,
    input logic [31:0] addr,
    input bit          wr,
    input logic [31:0] wd,
    input logic [3:0]  wm,
    input int          lat,
    input logic [31:0] rd,
    input bit          churn,
    input int          exp_wait
  );
    int n;
    logic ea, eb;
    logic [31:0] era, erb;
    n = 0;
    while (!(bus.pmem_read || bus.pmem_write) && n < 12) begin
      @(negedge clk);
      n++;
      if (bus.resp_a || bus.resp_b) begin
        checks++;
        failures++;
        $display("FAIL early_resp got a=%b b=%b want 0",
                 bus.resp_a, bus.resp_b);
      end
    end
    checks++;
    if (n >= 12) begin
      failures++;
      $display("FAIL grant_timeout got none want side_b=%0b", side_b);
      return;
    end
    if (exp_wait >= 0 && n != exp_wait) begin
      failures++;
      $display("FAIL grant_latency got %0d want %0d", n, exp_wait);
    end
    checks++;
    if (bus.pmem_read !== !wr || bus.pmem_write !== wr ||
        bus.pmem_address !== addr) begin
      failures++;
      $display("FAIL pmem_req got r=%b w=%b a=%h want r=%b w=%b a=%h",
               bus.pmem_read, bus.pmem_write, bus.pmem_address,
               !wr, wr, addr);
    end
    if (wr) begin
      checks++;
      if (bus.pmem_wdata !== wd || bus.pmem_wmask !== wm) begin
        failures++;
        $display("FAIL pmem_wr_data got %h/%h want %h/%h",
                 bus.pmem_wdata, bus.pmem_wmask, wd, wm);
      end
    end
    if (churn) begin
      if (side_b) begin
        bus.address_b = bus.address_b + 32'd4;
        bus.wdata     = ~bus.wdata;
        bus.wmask     = ~bus.wmask;
      end else begin
        bus.address_a = bus.address_a + 32'd4;
      end
    end
    for (int i = 1; i < lat; i++) begin
      @(negedge clk);
      checks++;
      if (bus.pmem_read !== !wr || bus.pmem_write !== wr ||
          bus.pmem_address !== addr ||
          (wr && (bus.pmem_wdata !== wd || bus.pmem_wmask !== wm)) ||
          bus.resp_a !== 1'b0 || bus.resp_b !== 1'b0) begin
        failures++;
        $display("FAIL hold got r=%b w=%b a=%h ra=%b rb=%b want a=%h",
                 bus.pmem_read, bus.pmem_write, bus.pmem_address,
                 bus.resp_a, bus.resp_b, addr);
      end
    end
    bus.pmem_rdata = rd;
    bus.pmem_resp  = 1'b1;
    #1;
    ea  = !side_b;
    eb  = side_b;
    era = side_b ? 32'h0 : rd;
    erb = (side_b && !wr) ? rd : 32'h0;
    checks++;
    if (bus.resp_a !== ea || bus.resp_b !== eb ||
        bus.rdata_a !== era || bus.rdata_b !== erb) begin
      failures++;
      $display("FAIL resp got a=%b/%h b=%b/%h want a=%b/%h b=%b/%h",
               bus.resp_a, bus.rdata_a, bus.resp_b, bus.rdata_b,
               ea, era, eb, erb);
    end
    if (side_b) begin
      bus.read_b = 1'b0;
      bus.write  = 1'b0;
    end else begin
      bus.read_a = 1'b0;
    end
    @(negedge clk);
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = $urandom;
    #1;
    checks++;
    if (bus.pmem_read !== 1'b0 || bus.pmem_write !== 1'b0 ||
        bus.resp_a !== 1'b0 || bus.resp_b !== 1'b0 ||
        bus.rdata_a !== 32'h0 || bus.rdata_b !== 32'h0) begin
      failures++;
      $display("FAIL dead_cycle got r=%b w=%b ra=%b rb=%b want 0",
               bus.pmem_read, bus.pmem_write,
               bus.resp_a, bus.resp_b);
    end
  endtask

  // Present requests at a negedge in IDLE; serve in model order.
  task automatic run_req(
    input bit          ra,
    input bit          rb,
    input bit          wb,
    input logic [31:0] aa,
    input logic [31:0] ab,
    input logic [31:0] wd,
    input logic [3:0]  wm,
    input int          lat1,
    input logic [31:0] rd1,
    input bit          churn
  );
    bit first_b;
    bit both;
    bus.read_a    = ra;
    bus.address_a = aa;
    bus.read_b    = rb;
    bus.write     = wb;
    bus.address_b = ab;
    bus.wdata     = wd;
    bus.wmask     = wm;
    both = ra && (rb || wb);
    if (both) begin
`ifdef MEM_ARB_DPRIO_EN
      first_b = 1'b1;
`else
      first_b      = model_last_a;
      model_last_a = !first_b;
`endif
    end else begin
      first_b = !ra;
    end
    if (first_b)
      do_txn(1'b1, ab, wb, wd, wm, lat1, rd1, churn, 1);
    else
      do_txn(1'b0, aa, 1'b0, 32'h0, 4'h0, lat1, rd1, churn, 1);
    if (both) begin
      if (first_b)
        do_txn(1'b0, aa, 1'b0, 32'h0, 4'h0,
               $urandom_range(1, 4), $urandom, 1'b0, 1);
      else
        do_txn(1'b1, ab, wb, wd, wm,
               $urandom_range(1, 4), $urandom, 1'b0, 1);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    model_last_a = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.pmem_read !== 1'b0 || bus.pmem_write !== 1'b0 ||
        bus.resp_a !== 1'b0 || bus.resp_b !== 1'b0 ||
        bus.pmem_address !== 32'h0 || bus.pmem_wdata !== 32'h0 ||
        bus.pmem_wmask !== 4'h0) begin
      failures++;
      $display("FAIL reset_state got r=%b w=%b a=%h d=%h m=%h want 0",
               bus.pmem_read, bus.pmem_write, bus.pmem_address,
               bus.pmem_wdata, bus.pmem_wmask);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_a_read();
    run_req(1'b1, 1'b0, 1'b0, 32'h60, 32'h0, 32'h0, 4'h0,
            3, 32'h00000013, 1'b0);
  endtask

  task automatic test_b_write();
    run_req(1'b0, 1'b0, 1'b1, 32'h0, 32'h84, 32'hDEADBEEF, 4'hC,
            3, 32'h55AA55AA, 1'b0);
  endtask

  task automatic test_tie();
    repeat (2)
      run_req(1'b1, 1'b1, 1'b0, 32'h10, 32'h200, 32'h0, 4'h0,
              2, 32'h12345678, 1'b0);
  endtask

  task automatic test_churn();
    run_req(1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 32'h0, 4'h0,
            4, 32'hCAFEF00D, 1'b1);
    run_req(1'b0, 1'b1, 1'b1, 32'h0, 32'h400, 32'h01020304, 4'h3,
            3, 32'h0, 1'b1);
  endtask

  task automatic test_reset_mid();
    bus.read_b    = 1'b1;
    bus.address_b = 32'h300;
    @(negedge clk);
    checks++;
    if (bus.pmem_read !== 1'b1 || bus.pmem_address !== 32'h300) begin
      failures++;
      $display("FAIL rmid_start got r=%b a=%h want 1/300",
               bus.pmem_read, bus.pmem_address);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.pmem_read !== 1'b0 || bus.resp_b !== 1'b0) begin
      failures++;
      $display("FAIL rmid_during got r=%b rb=%b want 0",
               bus.pmem_read, bus.resp_b);
    end
    @(negedge clk);
    bus.read_b   = 1'b0;
    rst          = 1'b0;
    model_last_a = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = 32'hBADBAD00;
    #1;
    checks++;
    if (bus.resp_a !== 1'b0 || bus.resp_b !== 1'b0 ||
        bus.pmem_read !== 1'b0 || bus.pmem_write !== 1'b0 ||
        bus.rdata_b !== 32'h0) begin
      failures++;
      $display("FAIL rmid_after got ra=%b rb=%b r=%b want 0",
               bus.resp_a, bus.resp_b, bus.pmem_read);
    end
    @(negedge clk);
    bus.pmem_resp = 1'b0;
  endtask

  task automatic test_stray_resp();
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = 32'hFFFFFFFF;
    #1;
    checks++;
    if (bus.resp_a !== 1'b0 || bus.resp_b !== 1'b0 ||
        bus.rdata_a !== 32'h0 || bus.rdata_b !== 32'h0) begin
      failures++;
      $display("FAIL stray_resp got ra=%b rb=%b want 0",
               bus.resp_a, bus.resp_b);
    end
    @(negedge clk);
    bus.pmem_resp = 1'b0;
    checks++;
    if (bus.pmem_read !== 1'b0 || bus.pmem_write !== 1'b0) begin
      failures++;
      $display("FAIL stray_idle got r=%b w=%b want 0",
               bus.pmem_read, bus.pmem_write);
    end
    // Still IDLE: a fresh request must take the minimum latency.
    run_req(1'b1, 1'b0, 1'b0, 32'h20, 32'h0, 32'h0, 4'h0,
            1, 32'h0BADF00D, 1'b0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 40; k++) begin
      int pat;
      int kind;
      bit rb, wb;
      pat  = $urandom_range(1, 3);
      kind = $urandom_range(0, 2);
      rb   = (pat >= 2) && (kind != 1);
      wb   = (pat >= 2) && (kind != 0);
      run_req(pat[0], rb, wb, $urandom, $urandom, $urandom,
              4'($urandom), $urandom_range(1, 5), $urandom,
              1'($urandom));
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    idle_inputs();
    test_reset();
    test_a_read();
    test_b_write();
    test_tie();
    test_churn();
    test_reset_mid();
    test_stray_resp();
    test_tie();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
